nes_clk_scheduler: RTL
======================

# nes_clk_scheduler

Clock-enable scheduler for the NES core. It replaces the gated PLL-derived CPU and PPU clocks with single-cycle enables on MCLK. It also replaces the manual-clock mux with a run/halt/single-step state machine that stops only on whole CPU-cycle boundaries. It sits between the board switch/button synchronizers and `NES_ARCHITECUTRE`, and drives every NES sequential element's clock enable.

## Interface
- `CPU_DIV`, default 12: MCLK cycles per CPU cycle. Must be a multiple of `PPU_DIV`.
- `PPU_DIV`, default 4: MCLK cycles per PPU dot. Must be ≥ 2.
- `VGA_DIV`, default 2: MCLK cycles per VGA pixel enable. Must be ≥ 2.
- `MCLK` in 1: NES master clock; the only clock.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `ENABLE` in 1: run request (synchronous to MCLK).
- `STEP_MODE` in 1: 1 = single-step mode, 0 = free run.
- `STEP_REQ` in 1: synchronized step button, level; its rising edge triggers a step.
- `CPU_CE` out 1: one-MCLK CPU clock enable.
- `PPU_CE` out 1: one-MCLK PPU clock enable.
- `VGA_CE` out 1: free-running pixel enable; never halted.
- `HALTED` out 1: scheduler is in HALT.
- `CPU_CYCLES` out 32: count of CPU_CE pulses (see Configuration).

## Operation
- Counters: `ppu_cnt` runs 0..PPU_DIV-1 and `cpu_cnt` runs 0..CPU_DIV-1.
  - Both advance only in RUN or STEP, and wrap together at CPU_DIV boundaries.
  - Both are frozen at 0 in HALT.
- `vga_cnt` runs 0..VGA_DIV-1 continuously after reset.
- Registered outputs:
  - `PPU_CE` <= active && ppu_cnt==PPU_DIV-1.
  - `CPU_CE` <= active && cpu_cnt==CPU_DIV-1.
  - `VGA_CE` <= vga_cnt==VGA_DIV-1.
  - Here active = (state is RUN or STEP).
- `CPU_CE` always coincides with a `PPU_CE` pulse (the last dot of the CPU cycle).
- States:
  - **HALT**
    - `STEP_MODE`=0 && `ENABLE`: go to RUN.
    - `STEP_MODE`=1 && STEP_REQ rising (STEP_REQ && !step_q): go to STEP.
    - Otherwise stay in HALT.
  - **RUN**
    - At cpu_cnt==CPU_DIV-1, if (!ENABLE || STEP_MODE): go to HALT. The in-flight CPU cycle always completes.
  - **STEP**
    - Runs exactly one CPU cycle (CPU_DIV/PPU_DIV PPU_CE pulses, 1 CPU_CE), then goes to HALT at cpu_cnt==CPU_DIV-1.
- `step_q` samples STEP_REQ every MCLK in all states.
  - Rising edges seen in RUN or STEP are discarded, not queued.
  - Holding STEP_REQ high yields exactly one step.
- `CPU_CYCLES` increments by 1 on each CPU_CE and wraps modulo 2^32.
- Mid-operation ENABLE or STEP_MODE changes take effect only at the next CPU boundary. A partially executed CPU cycle is never truncated.

## Timing
- Reset values:
  - state = HALT; all counters = 0; step_q = 0.
  - CPU_CE = PPU_CE = VGA_CE = 0; HALTED = 1; CPU_CYCLES = 0.
- RESET_N low at any point, including mid-STEP: all of the above apply immediately (asynchronous), and no enable pulse is emitted afterwards until a new RUN or STEP.
- Default parameters, start condition sampled at edge 0:
  - PPU_CE is high for the cycle after edges 4, 8, 12.
  - CPU_CE is high for the cycle after edge 12.
  - In RUN the pattern repeats every 12 edges.
  - In STEP, HALTED is high after edge 12.
- HALTED is registered and equals (state==HALT).
- Steady state: PPU_CE duty = 1/PPU_DIV, CPU_CE duty = 1/CPU_DIV, no jitter.
- VGA_CE: first pulse after edge VGA_DIV following reset release, then every VGA_DIV edges, independent of state.

## Configuration
- `NES_CYCLE_COUNTER_EN` defined: CPU_CYCLES counter is implemented as above.
- Not defined: no counter flops; CPU_CYCLES is driven constant 0.

## Structure
- Shared package `nes_pkg` holds:
  - `nes_sched_state_t` (HALT, RUN, STEP enum).
  - Constants `NES_CPU_DIV`=12, `NES_PPU_DIV`=4, `NES_VGA_DIV`=2, which serve as parameter defaults.
- Sub-module `nes_ce_divider` (parameter DIV; inputs MCLK, RESET_N, advance, clear; outputs cnt, tc):
  - Instantiated for the PPU counter, the CPU counter and the VGA counter.
- Elaboration-time assertions on the divisibility and minimum-value rules.

## Test plan
- Reset release, ENABLE=0 -> HALTED=1, no CPU_CE/PPU_CE for 100 MCLK, VGA_CE every 2 MCLK.
- ENABLE=1, STEP_MODE=0 -> PPU_CE after edges 4, 8, 12, 16…; CPU_CE after edges 12, 24…; ENABLE dropped at edge 17 -> last CPU_CE after edge 24, HALTED=1 after 24.
- STEP_MODE=1, STEP_REQ held high for 50 MCLK -> exactly 3 PPU_CE, 1 CPU_CE, then HALTED; a second pulse during STEP is ignored.
- RUN with STEP_MODE raised mid-cycle (cpu_cnt=5) -> cycle completes at cpu_cnt=11, then HALT; subsequent step pulses advance one CPU cycle each.
- RESET_N asserted at cpu_cnt=7 during STEP -> outputs at reset values immediately; no CPU_CE for that step.
- With `NES_CYCLE_COUNTER_EN`, run 1000 CPU cycles -> CPU_CYCLES=1000; without the macro -> CPU_CYCLES=0 throughout.

Source files
------------

// File: rtl/nes_clk_scheduler_pkg.sv
// nes_pkg: shared types and constants for the NES clock-enable scheduler.
//   nes_sched_state_t : HALT / RUN / STEP scheduler states
//   NES_*_DIV         : default MCLK divide ratios (CPU, PPU dot, VGA pixel)
//   cnt_w()           : counter width needed for a divide ratio
package nes_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } nes_sched_state_t;

  localparam int NES_CPU_DIV = 12;
  localparam int NES_PPU_DIV = 4;
  localparam int NES_VGA_DIV = 2;

  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/nes_clk_scheduler_if.sv
// nes_clk_scheduler_if: control/enable bundle of the clock scheduler.
//   ENABLE, STEP_MODE, STEP_REQ : run/step controls (into scheduler)
//   CPU_CE, PPU_CE, VGA_CE      : single-MCLK clock enables (out of scheduler)
//   HALTED, CPU_CYCLES          : status (out of scheduler)
// slave = scheduler side, master = controller / testbench side.
interface nes_clk_scheduler_if;
  logic        ENABLE;
  logic        STEP_MODE;
  logic        STEP_REQ;
  logic        CPU_CE;
  logic        PPU_CE;
  logic        VGA_CE;
  logic        HALTED;
  logic [31:0] CPU_CYCLES;

  modport slave (
    input  ENABLE, STEP_MODE, STEP_REQ,
    output CPU_CE, PPU_CE, VGA_CE, HALTED, CPU_CYCLES
  );

  modport master (
    output ENABLE, STEP_MODE, STEP_REQ,
    input  CPU_CE, PPU_CE, VGA_CE, HALTED, CPU_CYCLES
  );
endinterface

// File: rtl/nes_ce_divider.sv
// nes_ce_divider: modulo-DIV counter used to derive clock enables.
//   MCLK, RESET_N : clock, async active-low reset
//   advance       : count this cycle
//   clear         : force count to 0 (wins over advance)
//   cnt           : current count 0..DIV-1
//   tc            : terminal count (cnt == DIV-1), combinational
module nes_ce_divider
  import nes_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic                  MCLK,
  input  logic                  RESET_N,
  input  logic                  advance,
  input  logic                  clear,
  output logic [cnt_w(DIV)-1:0] cnt,
  output logic                  tc
);
  localparam int W = cnt_w(DIV);

  logic [W-1:0] r_cnt;

  assign tc  = (r_cnt == W'(DIV - 1));
  assign cnt = r_cnt;

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N)     r_cnt <= '0;
    else if (clear)   r_cnt <= '0;
    else if (advance) r_cnt <= tc ? '0 : r_cnt + W'(1);
  end
endmodule

// File: rtl/nes_clk_scheduler.sv
// nes_clk_scheduler: NES clock-enable scheduler with run/halt/single-step.
//   MCLK, RESET_N : master clock, async active-low reset
//   bus (slave)   : ENABLE/STEP_MODE/STEP_REQ in; CPU_CE/PPU_CE/VGA_CE,
//                   HALTED, CPU_CYCLES out (all registered)
// Halting only happens on whole CPU-cycle boundaries, so a started CPU
// cycle always finishes. VGA_CE free-runs regardless of state.
// Optional macro NES_CYCLE_COUNTER_EN: implements the 32-bit CPU_CYCLES
// counter; otherwise CPU_CYCLES is tied to 0.
module nes_clk_scheduler
  import nes_pkg::*;
#(
  parameter int CPU_DIV = NES_CPU_DIV,
  parameter int PPU_DIV = NES_PPU_DIV,
  parameter int VGA_DIV = NES_VGA_DIV
) (
  input  logic                 MCLK,
  input  logic                 RESET_N,
  nes_clk_scheduler_if.slave   bus
);

  if (PPU_DIV < 2) begin : g_chk_ppu
    $error("nes_clk_scheduler: PPU_DIV must be >= 2");
  end
  if (VGA_DIV < 2) begin : g_chk_vga
    $error("nes_clk_scheduler: VGA_DIV must be >= 2");
  end
  if ((CPU_DIV < PPU_DIV) || ((CPU_DIV % PPU_DIV) != 0)) begin : g_chk_cpu
    $error("nes_clk_scheduler: CPU_DIV must be a multiple of PPU_DIV");
  end

  nes_sched_state_t r_state, w_next;
  logic r_step_q;
  logic r_cpu_ce, r_ppu_ce, r_vga_ce, r_halted;

  logic w_active, w_halt;
  logic w_ppu_tc, w_cpu_tc, w_vga_tc;
  logic [cnt_w(PPU_DIV)-1:0] w_ppu_cnt;
  logic [cnt_w(CPU_DIV)-1:0] w_cpu_cnt;
  logic [cnt_w(VGA_DIV)-1:0] w_vga_cnt;
  logic w_unused_cnt;

  assign w_active = (r_state != HALT);
  assign w_halt   = (r_state == HALT);

  // The PPU counter is also cleared at the CPU boundary so the two always
  // wrap together even if they were ever to drift.
  nes_ce_divider #(.DIV(PPU_DIV)) u_ppu_div (
    .MCLK(MCLK), .RESET_N(RESET_N),
    .advance(w_active), .clear(w_halt || (w_active && w_cpu_tc)),
    .cnt(w_ppu_cnt), .tc(w_ppu_tc)
  );

  nes_ce_divider #(.DIV(CPU_DIV)) u_cpu_div (
    .MCLK(MCLK), .RESET_N(RESET_N),
    .advance(w_active), .clear(w_halt),
    .cnt(w_cpu_cnt), .tc(w_cpu_tc)
  );

  nes_ce_divider #(.DIV(VGA_DIV)) u_vga_div (
    .MCLK(MCLK), .RESET_N(RESET_N),
    .advance(1'b1), .clear(1'b0),
    .cnt(w_vga_cnt), .tc(w_vga_tc)
  );

  // Raw counts are only needed through their terminal-count flags here.
  assign w_unused_cnt = ^{w_ppu_cnt, w_cpu_cnt, w_vga_cnt};

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= HALT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALT: begin
        if (!bus.STEP_MODE && bus.ENABLE)
          w_next = RUN;
        else if (bus.STEP_MODE && bus.STEP_REQ && !r_step_q)
          w_next = STEP;
      end
      RUN:     if (w_cpu_tc && (!bus.ENABLE || bus.STEP_MODE)) w_next = HALT;
      STEP:    if (w_cpu_tc) w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  // step_q tracks STEP_REQ in every state, so an edge that arrives while
  // running is consumed and never replayed once halted.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_step_q <= 1'b0;
      r_cpu_ce <= 1'b0;
      r_ppu_ce <= 1'b0;
      r_vga_ce <= 1'b0;
      r_halted <= 1'b1;
    end else begin
      r_step_q <= bus.STEP_REQ;
      r_cpu_ce <= w_active && w_cpu_tc;
      r_ppu_ce <= w_active && w_ppu_tc;
      r_vga_ce <= w_vga_tc;
      r_halted <= (w_next == HALT);
    end
  end

  assign bus.CPU_CE = r_cpu_ce;
  assign bus.PPU_CE = r_ppu_ce;
  assign bus.VGA_CE = r_vga_ce;
  assign bus.HALTED = r_halted;

`ifdef NES_CYCLE_COUNTER_EN
  logic [31:0] r_cpu_cycles;

  // Counts on the same edge that raises CPU_CE, so it already includes
  // the pulse currently on the output.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N)                  r_cpu_cycles <= '0;
    else if (w_active && w_cpu_tc) r_cpu_cycles <= r_cpu_cycles + 32'd1;
  end

  assign bus.CPU_CYCLES = r_cpu_cycles;
`else
  assign bus.CPU_CYCLES = '0;
`endif

endmodule
